score_uart_reporter: RTL
========================

Name: score_uart_reporter

Overview:
- UART transmitter that reports game status to the host. It is the transmit end of the link whose receive end feeds the control module.
- Watches the tetris state code and score. Whenever either changes, or on an explicit request, it sends one ASCII status line on uart_tx.
- Sits beside the LCD text formatter in the top level and is driven from the same 50 MHz clock domain.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer division (434 at the defaults).

Ports:
- clk  in  1  system clock (50 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- state  in  8  current tetris state code (state_type cast to 8 bits).
- score  in  16  current score, 4 hex digits.
- send_req  in  1  single-cycle pulse; forces one report.
- uart_tx  out  1  serial line, 8N1, idle high.
- busy  out  1  high from the first start bit through the end of the last stop bit of a message.

Behaviour:
- Reset (async, reset_n=0):
  - uart_tx=1, busy=0, FSM=IDLE, byte index=0, req_pend=0.
  - last_sent={8'h00,16'h0000}.
  - Takes effect immediately, including mid-bit; any partial message is abandoned.
- Message: 11 bytes, transmitted in this order:
  - 'S', hex(state[7:4]), hex(state[3:0]), ' ', 'P', hex(score[15:12]) ... hex(score[3:0]), 8'h0D, 8'h0A.
- hex(n): n<10 gives "0"+n; otherwise "A"+n-10 (uppercase).
- Top FSM:
  - IDLE: each cycle, if send_req | req_pend | ({state,score} != last_sent), then:
    - snap <= {state,score}; last_sent <= {state,score}; req_pend <= 0.
    - Go to SEND.
  - SEND: hand bytes 0..10 of snap to the serializer via valid/ready.
    - After byte 10's stop bit completes, return to IDLE.
- Coalescing and requests:
  - Input changes during SEND are not queued. On return to IDLE they are compared against last_sent, so only the newest values are sent.
  - send_req during SEND sets req_pend. Multiple requests collapse into one extra message.
- Serializer: states IDLE, START, DATA, STOP.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Data bits are sent LSB first.
  - ready=1 only in IDLE. A byte accepted on a valid&ready cycle drives its start bit on the next cycle.
- Timing:
  - Latency: trigger seen in IDLE at cycle T, snapshot at T+1, uart_tx falls at T+2. busy rises with uart_tx falling.
  - Inter-byte gap is exactly 1 idle-high cycle (the handshake cycle).
  - busy falls on the cycle after the final stop bit ends.
- Snapshot: held constant for the whole message; input changes never corrupt an in-flight message.
- Simultaneous send_req and input change in IDLE: one message only.

Optional Feature:
- Macro REPORTER_PARITY_EN.
- Defined:
  - Frame is 8E1: an even-parity bit (XOR of the 8 data bits) follows the data bits for CLKS_PER_BIT cycles.
  - Serializer gains a PARITY state between DATA and STOP.
  - Message length = 11 bytes × 11 bits.
- Undefined: 8N1 exactly as above, no PARITY state.

Decomposition:
- Shared package enum_type gets:
  - rpt_state_type {RPT_IDLE, RPT_SEND}.
  - ser_state_type {SER_IDLE, SER_START, SER_DATA, SER_PARITY, SER_STOP}.
  - Constants MSG_LEN=11, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
- One sub-module: uart_tx_byte.
  - Ports: clk, reset_n, data[7:0], valid, ready, tx.
  - Owns the baud counter, bit counter and shifter.
- The top holds the message sequencer, change detector and hex formatter.

Test Plan (sim with CLK_HZ=1000, BAUD=100 → 10 clks/bit; 8N1 message = 1100 bits-cycles plus gaps):
- Reset, state=0, score=0 held for 3000 cycles -> uart_tx constantly 1, busy constantly 0.
- state=8'h03, score=16'h012C applied -> decoded bytes 53 30 33 20 50 30 31 32 43 0D 0A. uart_tx low exactly 2 cycles after the change; busy high continuously until the last stop bit ends.
- During that message, score stepped 0x012D, 0x012E, 0x0130 -> exactly one further message "S03 P0130\r\n", then idle.
- send_req pulse with inputs unchanged -> one resend of the identical 11 bytes. Two pulses during a message -> exactly one extra message.
- reset_n low at bit 4 of byte 2 -> uart_tx=1 and busy=0 in the same cycle. After release with inputs 0x03/0x012C -> full message restarts from 'S'.
- REPORTER_PARITY_EN defined, message for state=8'h03, score=16'h012C -> each frame is 11 bits. Parity bit for 0x53 is 0 and for 0x43 is 1.

Source files
------------

// File: rtl/score_uart_reporter_pkg.sv
// Shared types, message constants and ASCII formatting helpers for the score reporter.
package enum_type;

  typedef enum logic [0:0] {RPT_IDLE, RPT_SEND} rpt_state_type;
  typedef enum logic [2:0] {SER_IDLE, SER_START, SER_DATA, SER_PARITY, SER_STOP} ser_state_type;

  localparam int unsigned MSG_LEN  = 11;
  localparam logic [7:0]  ASCII_CR = 8'h0D;
  localparam logic [7:0]  ASCII_LF = 8'h0A;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // snap = {state[7:0], score[15:0]}; idx selects one byte of "Sss Pdddd\r\n"
  function automatic logic [7:0] msg_byte(input logic [23:0] snap, input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h53;
      4'd1:    b = hex_ascii(snap[23:20]);
      4'd2:    b = hex_ascii(snap[19:16]);
      4'd3:    b = 8'h20;
      4'd4:    b = 8'h50;
      4'd5:    b = hex_ascii(snap[15:12]);
      4'd6:    b = hex_ascii(snap[11:8]);
      4'd7:    b = hex_ascii(snap[7:4]);
      4'd8:    b = hex_ascii(snap[3:0]);
      4'd9:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/score_uart_reporter_uart_tx_byte.sv
// Single-byte UART serializer, 8N1 by default; 8E1 when REPORTER_PARITY_EN is defined.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  import enum_type::*;

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  ser_state_type state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
`ifdef REPORTER_PARITY_EN
  logic          par_q, par_d;
`endif
  logic          bit_end;

  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign ready   = (state_q == SER_IDLE);
  assign tx      = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef REPORTER_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != SER_IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    case (state_q)
      SER_IDLE: begin
        tx_d = 1'b1;
        if (valid) begin
          state_d = SER_START;
          shift_d = data;
          cnt_d   = '0;
          tx_d    = 1'b0;
`ifdef REPORTER_PARITY_EN
          par_d   = ^data;
`endif
        end
      end
      SER_START: begin
        if (bit_end) begin
          state_d = SER_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      SER_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef REPORTER_PARITY_EN
            state_d = SER_PARITY;
            tx_d    = par_q;
`else
            state_d = SER_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef REPORTER_PARITY_EN
      SER_PARITY: begin
        if (bit_end) begin
          state_d = SER_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      SER_STOP: begin
        if (bit_end) state_d = SER_IDLE;
      end
      default: begin
        state_d = SER_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SER_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef REPORTER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef REPORTER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: rtl/score_uart_reporter.sv
// Sends "Sss Pdddd\r\n" over UART whenever state/score change or on send_req.
// Frame format follows REPORTER_PARITY_EN (8E1 when defined, else 8N1).
module score_uart_reporter #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  state,
  input  logic [15:0] score,
  input  logic        send_req,
  output logic        uart_tx,
  output logic        busy
);
  import enum_type::*;

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

  rpt_state_type rpt_q, rpt_d;
  logic [23:0]   snap_q, snap_d;
  logic [23:0]   last_q, last_d;
  logic [3:0]    idx_q, idx_d;
  logic          req_q, req_d;
  logic          busy_q, busy_d;
  logic          ser_valid, ser_ready;
  logic [7:0]    ser_data;
  logic          all_sent;

  assign all_sent = (idx_q == 4'(MSG_LEN));
  assign ser_data = msg_byte(snap_q, idx_q);
  // busy drops as soon as the last stop bit ends, one cycle before the sequencer returns to idle
  assign busy     = busy_q & ~(ser_ready & all_sent);

  always_comb begin
    rpt_d     = rpt_q;
    snap_d    = snap_q;
    last_d    = last_q;
    idx_d     = idx_q;
    req_d     = req_q;
    busy_d    = busy_q;
    ser_valid = 1'b0;
    case (rpt_q)
      RPT_IDLE: begin
        if (send_req || req_q || ({state, score} != last_q)) begin
          snap_d = {state, score};
          last_d = {state, score};
          req_d  = 1'b0;
          idx_d  = '0;
          rpt_d  = RPT_SEND;
        end
      end
      RPT_SEND: begin
        if (send_req) req_d = 1'b1;
        if (!all_sent) begin
          ser_valid = 1'b1;
          if (ser_ready) begin
            idx_d  = idx_q + 4'd1;
            busy_d = 1'b1;
          end
        end else if (ser_ready) begin
          rpt_d  = RPT_IDLE;
          idx_d  = '0;
          busy_d = 1'b0;
        end
      end
      default: rpt_d = RPT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_q  <= RPT_IDLE;
      snap_q <= '0;
      last_q <= '0;
      idx_q  <= '0;
      req_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rpt_q  <= rpt_d;
      snap_q <= snap_d;
      last_q <= last_d;
      idx_q  <= idx_d;
      req_q  <= req_d;
      busy_q <= busy_d;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk     (clk),
    .reset_n (reset_n),
    .data    (ser_data),
    .valid   (ser_valid),
    .ready   (ser_ready),
    .tx      (uart_tx)
  );

endmodule
